// File: rtl/bullet_launcher_if.sv
// bullet_launcher_if: control inputs and bullet state outputs of the bullet launcher
interface bullet_launcher_if;
    logic [3:0] angle;
    logic       fire;
    logic       frame_tick;
    logic       hit;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_active;
    logic       fire_accepted;
    logic       bullet_done;
    modport master (
        output angle, fire, frame_tick, hit,
        input  bullet_x, bullet_y, bullet_active, fire_accepted, bullet_done
    );
    modport slave (
        input  angle, fire, frame_tick, hit,
        output bullet_x, bullet_y, bullet_active, fire_accepted, bullet_done
    );
endinterface

// File: rtl/bullet_launcher.sv
// bullet_launcher: single-bullet engine that launches, moves per frame and retires one projectile
module bullet_launcher #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int ORIGIN_X       = 320,
    parameter int ORIGIN_Y       = 240,
    parameter int SPEED_SHIFT    = 0,
    parameter int COOLDOWN_TICKS = 4
) (
    input logic clk,
    input logic reset,
    bullet_launcher_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;
    localparam int CW = COOLDOWN_TICKS > 1 ? $clog2(COOLDOWN_TICKS) : 1;
    state_t state, state_n;
    logic fire_d, fire_edge;
    logic [9:0] x, y, x_n, y_n;
    logic [11:0] dx, dy, dx_n, dy_n, nx, ny;
    logic signed [4:0] bdx, bdy;
    logic [CW-1:0] cnt, cnt_n;
    logic active, active_n, accepted_n, done_n, accepted, done, in_bounds;
    assign fire_edge = bus.fire & ~fire_d;
    assign nx = {2'b00, x} + dx;
    assign ny = {2'b00, y} + dy;
    assign in_bounds = !nx[11] && nx < 12'(SCREEN_W) && !ny[11] && ny < 12'(SCREEN_H);
    assign bus.bullet_x = x;
    assign bus.bullet_y = y;
    assign bus.bullet_active = active;
    assign bus.fire_accepted = accepted;
    assign bus.bullet_done = done;
    // heading table: unit step per angle, screen y grows downward
    always_comb begin
        bdx = 5'sd0;
        bdy = -5'sd8;
        case (bus.angle)
            4'd1:  begin bdx = 5'sd3;  bdy = -5'sd7; end
            4'd2:  begin bdx = 5'sd6;  bdy = -5'sd6; end
            4'd3:  begin bdx = 5'sd7;  bdy = -5'sd3; end
            4'd4:  begin bdx = 5'sd8;  bdy = 5'sd0;  end
            4'd5:  begin bdx = 5'sd7;  bdy = 5'sd3;  end
            4'd6:  begin bdx = 5'sd6;  bdy = 5'sd6;  end
            4'd7:  begin bdx = 5'sd3;  bdy = 5'sd7;  end
            4'd8:  begin bdx = 5'sd0;  bdy = 5'sd8;  end
            4'd9:  begin bdx = -5'sd3; bdy = 5'sd7;  end
            4'd10: begin bdx = -5'sd6; bdy = 5'sd6;  end
            4'd11: begin bdx = -5'sd7; bdy = 5'sd3;  end
            4'd12: begin bdx = -5'sd8; bdy = 5'sd0;  end
            4'd13: begin bdx = -5'sd7; bdy = -5'sd3; end
            4'd14: begin bdx = -5'sd6; bdy = -5'sd6; end
            4'd15: begin bdx = -5'sd3; bdy = -5'sd7; end
            default: begin bdx = 5'sd0; bdy = -5'sd8; end
        endcase
    end
    // next state: launch on edge in IDLE, move or retire in FLYING, count ticks in COOLDOWN
    always_comb begin
        state_n = state;
        x_n = x;
        y_n = y;
        dx_n = dx;
        dy_n = dy;
        cnt_n = cnt;
        active_n = active;
        accepted_n = 1'b0;
        done_n = 1'b0;
        case (state)
            IDLE: if (fire_edge) begin
                state_n = FLYING;
                active_n = 1'b1;
                accepted_n = 1'b1;
                x_n = 10'(ORIGIN_X);
                y_n = 10'(ORIGIN_Y);
                dx_n = 12'($signed(bdx)) << SPEED_SHIFT;
                dy_n = 12'($signed(bdy)) << SPEED_SHIFT;
            end
            FLYING: if (bus.hit || (bus.frame_tick && !in_bounds)) begin
                state_n = COOLDOWN;
                active_n = 1'b0;
                done_n = 1'b1;
                cnt_n = '0;
            end else if (bus.frame_tick) begin
                x_n = nx[9:0];
                y_n = ny[9:0];
            end
            COOLDOWN: if (bus.frame_tick) begin
                state_n = cnt == CW'(COOLDOWN_TICKS - 1) ? IDLE : COOLDOWN;
                cnt_n = cnt == CW'(COOLDOWN_TICKS - 1) ? '0 : cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // state register with synchronous reset to the launch origin
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fire_d <= 1'b0;
            x <= 10'(ORIGIN_X);
            y <= 10'(ORIGIN_Y);
            dx <= '0;
            dy <= '0;
            cnt <= '0;
            active <= 1'b0;
            accepted <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            fire_d <= bus.fire;
            x <= x_n;
            y <= y_n;
            dx <= dx_n;
            dy <= dy_n;
            cnt <= cnt_n;
            active <= active_n;
            accepted <= accepted_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_bullet_launcher.sv
// tb_bullet_launcher: scoreboard bench for two launchers (normal and double speed)
module tb_bullet_launcher;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bullet_launcher_if b0 ();
    bullet_launcher_if b1 ();
    bullet_launcher #(.SPEED_SHIFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    bullet_launcher #(.SPEED_SHIFT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    always #5 clk = ~clk;
    typedef struct {int x; int y; int a; int fa; int bd;} exp_t;
    exp_t q[$];
    int n_checks = 0, n_errors = 0, fa_cnt = 0;
    int ldx[16] = '{0, 3, 6, 7, 8, 7, 6, 3, 0, -3, -6, -7, -8, -7, -6, -3};
    int ldy[16] = '{-8, -7, -6, -3, 0, 3, 6, 7, 8, 7, 6, 3, 0, -3, -6, -7};
    int ms = 0, mx = 320, my = 240, ma = 0, mfa = 0, mbd = 0, mcnt = 0, mfd = 0, vdx = 0, vdy = 0;
    logic [3:0] ang = 4'd0;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step(input int f, input int t, input int h, input int r);
        exp_t e, g;
        int nx, ny;
        @(negedge clk);
        reset = 1'(r);
        {b0.fire, b0.frame_tick, b0.hit, b0.angle} = {1'(f), 1'(t), 1'(h), ang};
        {b1.fire, b1.frame_tick, b1.hit, b1.angle} = {1'(f), 1'(t), 1'(h), ang};
        mfa = 0;
        mbd = 0;
        if (r != 0) begin
            ms = 0; mx = 320; my = 240; ma = 0; mcnt = 0; mfd = 0;
        end else begin
            if (ms == 0 && f != 0 && mfd == 0) begin
                ms = 1; ma = 1; mfa = 1; mx = 320; my = 240;
                vdx = ldx[ang]; vdy = ldy[ang];
            end else if (ms == 1 && (h != 0 || t != 0)) begin
                nx = mx + vdx;
                ny = my + vdy;
                if (h == 0 && nx >= 0 && nx < 640 && ny >= 0 && ny < 480) begin
                    mx = nx; my = ny;
                end else begin
                    ms = 2; ma = 0; mbd = 1; mcnt = 0;
                end
            end else if (ms == 2 && t != 0) begin
                mcnt++;
                if (mcnt == 4) begin
                    ms = 0; mcnt = 0;
                end
            end
            mfd = f;
        end
        q.push_back('{mx, my, ma, mfa, mbd});
        @(posedge clk);
        #1;
        e = q.pop_front();
        g = '{int'(b0.bullet_x), int'(b0.bullet_y), int'(b0.bullet_active), int'(b0.fire_accepted), int'(b0.bullet_done)};
        check("sb_x", g.x, e.x);
        check("sb_y", g.y, e.y);
        check("sb_active", g.a, e.a);
        check("sb_accepted", g.fa, e.fa);
        check("sb_done", g.bd, e.bd);
        check("pulse_excl", g.fa & g.bd, 0);
        if (b0.fire_accepted) fa_cnt++;
    endtask
    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_x", int'(b0.bullet_x), 320);
        check("rst_y", int'(b0.bullet_y), 240);
        check("rst_active", int'(b0.bullet_active), 0);
        ang = 4'd4;
        step(1, 0, 0, 0);
        check("t1_accept", int'(b0.fire_accepted), 1);
        check("t1_active", int'(b0.bullet_active), 1);
        repeat (3) step(1, 1, 0, 0);
        check("t1_x", int'(b0.bullet_x), 344);
        check("t1_y", int'(b0.bullet_y), 240);
        step(0, 0, 1, 0);
        repeat (4) step(0, 1, 0, 0);
        ang = 4'd2;
        step(1, 0, 0, 0);
        check("t2_accept", int'(b0.fire_accepted), 1);
        ang = 4'd10;
        step(1, 1, 0, 0);
        check("t2_x1", int'(b0.bullet_x), 326);
        check("t2_y1", int'(b0.bullet_y), 234);
        step(1, 1, 0, 0);
        check("t2_x2", int'(b0.bullet_x), 332);
        check("t2_y2", int'(b0.bullet_y), 228);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        ang = 4'd0;
        step(1, 0, 0, 0);
        repeat (30) step(0, 1, 0, 0);
        check("t3_y0", int'(b0.bullet_y), 0);
        check("t3_active", int'(b0.bullet_active), 1);
        step(0, 1, 0, 0);
        check("t3_done", int'(b0.bullet_done), 1);
        check("t3_inactive", int'(b0.bullet_active), 0);
        check("t3_yhold", int'(b0.bullet_y), 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            check("t3_cd_drop", int'(b0.fire_accepted), 0);
            step(0, 1, 0, 0);
        end
        step(1, 0, 0, 0);
        check("t3_relaunch", int'(b0.fire_accepted), 1);
        step(0, 1, 1, 0);
        check("t4_done", int'(b0.bullet_done), 1);
        check("t4_inactive", int'(b0.bullet_active), 0);
        check("t4_nomove", int'(b0.bullet_y), 240);
        repeat (4) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        check("t4_idle_hit_active", int'(b0.bullet_active), 0);
        check("t4_idle_hit_done", int'(b0.bullet_done), 0);
        fa_cnt = 0;
        ang = 4'd4;
        repeat (60) step(1, 1, 0, 0);
        check("t5_one_accept", fa_cnt, 1);
        check("t5_x_edge", int'(b0.bullet_x), 632);
        check("t5_inactive", int'(b0.bullet_active), 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("t5_fly_x", int'(b0.bullet_x), 328);
        step(0, 0, 0, 1);
        check("t5_rst_active", int'(b0.bullet_active), 0);
        check("t5_rst_x", int'(b0.bullet_x), 320);
        check("t5_rst_y", int'(b0.bullet_y), 240);
        step(1, 0, 0, 0);
        check("t5_rst_idle", int'(b0.fire_accepted), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        ang = 4'd15;
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check("t6_fast_x", int'(b1.bullet_x), 314);
        check("t6_fast_y", int'(b1.bullet_y), 226);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        ang = 4'd12;
        step(1, 0, 0, 0);
        repeat (20) step(0, 1, 0, 0);
        check("t6_fast_x0", int'(b1.bullet_x), 0);
        check("t6_fast_active", int'(b1.bullet_active), 1);
        step(0, 1, 0, 0);
        check("t6_fast_done", int'(b1.bullet_done), 1);
        check("t6_fast_xhold", int'(b1.bullet_x), 0);
        check("t6_fast_inactive", int'(b1.bullet_active), 0);
        repeat (19) step(0, 1, 0, 0);
        check("t6_x0", int'(b0.bullet_x), 0);
        check("t6_active", int'(b0.bullet_active), 1);
        step(0, 1, 0, 0);
        check("t6_done", int'(b0.bullet_done), 1);
        check("t6_xhold", int'(b0.bullet_x), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
